// File: rtl/add_pkg.sv
// Shared constants and carry-lookahead helpers for the registered add datapath.
package add_pkg;
  localparam int WIDTH_DEF  = 32;
  localparam int CLA_GROUP  = 4;
  localparam int NUM_GROUPS = WIDTH_DEF / CLA_GROUP;

  // Lookahead carries into positions 0..3 of a 4-wide generate/propagate slice.
  function automatic logic [3:0] cla_carry(input logic [3:0] g, input logic [3:0] p,
                                           input logic cin);
    logic [3:0] cy;
    cy[0] = cin;
    cy[1] = g[0] | (p[0] & cin);
    cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return cy;
  endfunction

  function automatic logic cla_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction
endpackage

// File: rtl/add_cla4.sv
// 4-bit carry-lookahead group: sum bits plus group generate/propagate.
module add_cla4
  import add_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] s,
  output logic                 G,
  output logic                 P
);
  logic [CLA_GROUP-1:0] g, p, cy;

  assign g  = a & b;
  assign p  = a ^ b;
  assign cy = cla_carry(g, p, cin);
  assign s  = p ^ cy;
  assign G  = cla_gen(g, p);
  assign P  = &p;
endmodule

// File: rtl/add.sv
// Registered unsigned adder: 4-bit CLA groups, 4-group lookahead blocks, block carry chain.
module add
  import add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             c
);
  localparam int NG = WIDTH / CLA_GROUP;
  localparam int NB = (NG + 3) / 4;

  logic [NG-1:0]     grp_g, grp_p;
  logic [NB*4-1:0]   gg, gp, gcin;
  logic [NB:0]       blk_cin;
  logic [WIDTH-1:0]  s_int;

  genvar gi, bi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      add_cla4 u_cla4 (
        .a   (a[gi*CLA_GROUP +: CLA_GROUP]),
        .b   (b[gi*CLA_GROUP +: CLA_GROUP]),
        .cin (gcin[gi]),
        .s   (s_int[gi*CLA_GROUP +: CLA_GROUP]),
        .G   (grp_g[gi]),
        .P   (grp_p[gi])
      );
    end
  endgenerate

  // Pad the group G/P vectors to whole 4-group blocks; pad groups never generate or propagate.
  always_comb begin
    gg = '0;
    gp = '0;
    gg[NG-1:0] = grp_g;
    gp[NG-1:0] = grp_p;
  end

  assign blk_cin[0] = 1'b0;

  generate
    for (bi = 0; bi < NB; bi++) begin : g_blk
      logic blk_g, blk_p;
      assign gcin[bi*4 +: 4] = cla_carry(gg[bi*4 +: 4], gp[bi*4 +: 4], blk_cin[bi]);
      assign blk_g           = cla_gen(gg[bi*4 +: 4], gp[bi*4 +: 4]);
      assign blk_p           = &gp[bi*4 +: 4];
      assign blk_cin[bi+1]   = blk_g | (blk_p & blk_cin[bi]);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      sum <= '0;
      c   <= 1'b0;
    end else begin
      sum <= s_int;
      c   <= blk_cin[NB];
    end
  end
endmodule

// File: tb/tb_add.sv
// Scoreboard bench for the registered 32-bit adder.
module tb_add;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] a, b, sum;
  logic        c;

  logic [32:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  add #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .c     (c)
  );

  // Apply operands shortly after a posedge; the result is due after the next posedge.
  task automatic drive(input logic r, input logic [31:0] av, input logic [31:0] bv,
                       input logic [32:0] exp, input string tag);
    @(posedge clock);
    #2;
    reset = r;
    a     = av;
    b     = bv;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  logic [32:0] m_exp;
  string       m_tag;
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      checks++;
      if ({c, sum} !== m_exp) begin
        errors++;
        $display("FAIL %s: got c=%0b sum=%h, expected c=%0b sum=%h",
                 m_tag, c, sum, m_exp[32], m_exp[31:0]);
      end
    end
  end

  initial begin
    logic [31:0] av, bv;
    reset = 1'b1;
    a = '0;
    b = '0;

    drive(1'b1, 32'd0, 32'd0, 33'd0, "reset");
    drive(1'b1, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 33'd0, "reset_x_inputs");
    drive(1'b0, 32'd23, 32'd34, 33'd57, "basic_23_34");
    drive(1'b0, 32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000, "full_ripple");
    drive(1'b0, 32'h0000_FFFF, 32'd1, 33'h0_0001_0000, "group_chain");
    drive(1'b0, 32'h0FFF_FFFF, 32'd1, 33'h0_1000_0000, "block_chain");
    drive(1'b0, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000, "msb_overflow");
    drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, "all_ones");
    drive(1'b0, 32'h1234_5678, 32'h8765_4321, 33'h0_9999_9999, "mixed_no_carry");
    drive(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 33'h0_FFFF_FFFF, "alt_propagate");
    drive(1'b0, 32'd0, 32'd0, 33'd0, "zero");

    for (int i = 0; i < 200; i++) begin
      av = 32'($urandom_range(0, 1));
      bv = 32'($urandom_range(0, 1));
      drive(1'b0, av, bv, {1'b0, av} + {1'b0, bv}, "small_rand");
    end

    drive(1'b1, 32'd100, 32'd200, 33'd0, "mid_reset");
    drive(1'b0, 32'd100, 32'd200, 33'd300, "post_reset");

    for (int i = 0; i < 1000; i++) begin
      av = $urandom;
      bv = $urandom;
      drive(1'b0, av, bv, {1'b0, av} + {1'b0, bv}, "b2b_rand");
    end

    repeat (3) @(posedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results still pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
